pipe_stage_elastic: RTL

Parametrised, elastic successor to the fixed D-to-E pipeline latch, intended to replace the D/E, E/M and M/W stage registers. Moves one control word plus one datapath word per cycle under a valid/ready handshake. A two-entry skid buffer lets backpressure propagate without a combinational ready path. Supports synchronous flush, which inserts a bubble with all control bits zeroed so RegWrite and MemWrite can never fire on a squashed slot.

---
 rtl/pipe_stage_elastic.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic pipeline stage register: one control word plus one datapath
//   word per cycle under a valid/ready handshake. A main entry plus a skid
//   entry absorb one cycle of backpressure, so in_ready is decoded from the
//   state register alone and has no combinational path from out_ready.
//   flush squashes both entries and zeroes the held control bits, so a
//   squashed slot can never carry RegWrite/MemWrite downstream.
//
// Parameters
//   CTRL_W          control bundle width (zeroed on bubbles)
//   DATA_W          datapath bundle width
//   FLUSH_CLR_DATA  1: flush also clears stored data; 0: data left stale
//
// Ports
//   CLK        in   clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   flush      in   synchronous squash of all held entries
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept (registered decode)
//   in_ctrl    in   upstream control bundle
//   in_data    in   upstream datapath bundle
//   out_valid  out  main entry valid
//   out_ready  in   downstream accepts this cycle
//   out_ctrl   out  main control bundle, 0 whenever out_valid=0
//   out_data   out  main datapath bundle
//
// Optional feature (macro PIPE_PERF_CNT_EN)
//   stall_cnt  out  [31:0] cycles with in_valid & !in_ready (saturating)
//   bubble_cnt out  [31:0] cycles with out_ready & !out_valid (saturating)
//   flush_cnt  out  [15:0] cycles with flush while not EMPTY (saturating)

module pipe_stage_elastic #(
    parameter int CTRL_W         = 16,
    parameter int DATA_W         = 32,
    parameter int FLUSH_CLR_DATA = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_ld_main_in;
    logic w_ld_skid_in;
    logic w_ld_main_skid;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (in_valid) w_state_nxt = S_BUSY;
                S_BUSY: begin
                    if (in_valid && !out_ready)      w_state_nxt = S_FULL;
                    else if (!in_valid && out_ready) w_state_nxt = S_EMPTY;
                end
                S_FULL:  if (out_ready) w_state_nxt = S_BUSY;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Outputs: handshake flags come straight from the state register
    always_comb begin
        in_ready  = (r_state != S_FULL);
        out_valid = (r_state != S_EMPTY);
        out_ctrl  = out_valid ? r_main_ctrl : '0;
        out_data  = r_main_data;
    end

    // Register load enables. A flushed cycle records no accept.
    always_comb begin
        w_ld_main_in   = !flush && in_valid &&
                         ((r_state == S_EMPTY) || (r_state == S_BUSY && out_ready));
        w_ld_skid_in   = !flush && in_valid && (r_state == S_BUSY) && !out_ready;
        w_ld_main_skid = !flush && (r_state == S_FULL) && out_ready;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            // Control is always zeroed so a squashed slot is a true bubble
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
            if (FLUSH_CLR_DATA != 0) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end
        end else begin
            if (w_ld_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_ld_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_ld_skid_in) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (in_valid && !in_ready && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (out_ready && !out_valid && r_bubble_cnt != '1)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (flush && r_state != S_EMPTY && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

endmodule
